// File: rtl/de2_115_key_debounce.sv
// de2_115_key_debounce
//
// Conditions the DE2-115 push-buttons for the input PIO. Each raw
// active-low key pin passes through a two-flop synchronizer. A per-bit
// stability counter then accepts a new level only after it has held for
// DEBOUNCE_CYCLES consecutive clocks.
//
// Optional feature macro: KEY_DEBOUNCE_EVENTS_EN
//   defined   - press_pulse / release_pulse are registered one-cycle events
//   undefined - both event ports are tied to 0 and no event flops exist
//
// Ports:
//   clk           in   system clock (single domain)
//   reset_n       in   synchronous active-low reset
//   key_n_in      in   [WIDTH] raw asynchronous key pins, 0 = pressed
//   key_out       out  [WIDTH] debounced level, same polarity as the pins
//   press_pulse   out  [WIDTH] one-cycle pulse when key_out[i] falls
//   release_pulse out  [WIDTH] one-cycle pulse when key_out[i] rises
module de2_115_key_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_n_in,
    output logic [WIDTH-1:0] key_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] sync0_q, sync0_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] key_out_q, key_out_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    // Bit i completes its stability interval on this edge.
    logic [WIDTH-1:0] accept;

    always_comb begin
        sync0_d   = key_n_in;
        sync1_d   = sync0_q;
        key_out_d = key_out_q;
        accept    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // A pin that matches the accepted level restarts the interval,
            // which is what swallows bounces and short glitches.
            if (sync1_q[i] != key_out_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    accept[i]    = 1'b1;
                    key_out_d[i] = sync1_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync0_q   <= '1;
            sync1_q   <= '1;
            key_out_q <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync0_q   <= sync0_d;
            sync1_q   <= sync1_d;
            key_out_q <= key_out_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key_out = key_out_q;

`ifdef KEY_DEBOUNCE_EVENTS_EN
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;

    // The accepted new level decides the direction, so the two pulses of a
    // bit can never be high together.
    always_comb begin
        press_d   = accept & ~sync1_q;
        release_d = accept &  sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
`else
    assign press_pulse   = '0;
    assign release_pulse = '0;
`endif

endmodule
